pe_array_sequencer: RTL

Sequencer that configures and runs the 4-bit PE array. On `start` it streams one control word per PE from a valid/ready configuration source into the PEs' control registers, one PE at a time. It then asserts the array-wide enable for a programmed number of compute cycles and reports completion. It sits between the host/config memory and the PE array, and is the only driver of PE control-word loads and of the array enable.

---
 rtl/pe_array_sequencer_pkg.sv | 24 ++
 rtl/register.sv | 21 ++
 rtl/pe_array_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pe_array_sequencer_pkg.sv
// Shared types and constants for the PE array sequencer.
// The sequencer's optional parity check is enabled with the PE_SEQ_PARITY_EN macro.
package pe_array_sequencer_pkg;

    localparam int unsigned SEQ_CNT_W = 8;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LOAD   = 3'd1,
        SEQ_SETTLE = 3'd2,
        SEQ_RUN    = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_t;

    // One PE control word as it lands in the PE's control register.
    typedef struct packed {
        logic [2:0] sel_op_0;
        logic [2:0] sel_op_1;
        logic [1:0] alu_op;
    } ctrl_signals_t;

    localparam int unsigned CTRL_W = $bits(ctrl_signals_t);

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset to RESET_VAL.
module register #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pe_array_sequencer.sv
// Loads one control word per PE over valid/ready, then enables the array for run_cycles cycles.
// Define PE_SEQ_PARITY_EN to add the cfg_parity input and the sticky err flag.
module pe_array_sequencer
    import pe_array_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEQ_CNT_W-1:0] run_cycles,
    input  logic                 cfg_valid,
    input  logic [CTRL_W-1:0]    cfg_data,
`ifdef PE_SEQ_PARITY_EN
    input  logic                 cfg_parity,
`endif
    output logic                 cfg_ready,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [NUM_PE-1:0]    ctrl_load,
    output logic                 pe_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [SEQ_CNT_W-1:0] cnt;
    logic [SEQ_CNT_W-1:0] cnt_nxt;
    logic [SEQ_CNT_W-1:0] run_lat;
    logic                 xfer_c;
    logic                 start_c;
    logic                 last_c;
    logic                 par_bad_c;

    // Abort outranks both a start and a configuration transfer.
    assign start_c = (state == SEQ_IDLE) && start && !abort;
    assign xfer_c  = (state == SEQ_LOAD) && cfg_valid && !abort;
    assign last_c  = (idx == IDX_W'(NUM_PE - 1));

`ifdef PE_SEQ_PARITY_EN
    logic err_nxt;

    assign par_bad_c = xfer_c && (cfg_parity != (^cfg_data));

    // Sticky until the next accepted start; survives abort.
    always_comb begin
        err_nxt = err;
        if (start_c) begin
            err_nxt = 1'b0;
        end else if (par_bad_c) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`else
    assign par_bad_c = 1'b0;
    assign err       = 1'b0;
`endif

    register #(.WIDTH(SEQ_CNT_W)) u_run_lat (
        .clock (clock),
        .reset (reset),
        .en    (start_c),
        .d     (run_cycles),
        .q     (run_lat)
    );

    register #(.WIDTH(CTRL_W)) u_ctrl_out (
        .clock (clock),
        .reset (reset),
        .en    (xfer_c),
        .d     (cfg_data),
        .q     (ctrl_out)
    );

    // Next state, PE index and run counter.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = SEQ_IDLE;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (start_c) begin
                        state_nxt = SEQ_LOAD;
                        idx_nxt   = '0;
                    end
                end
                SEQ_LOAD: begin
                    if (xfer_c) begin
                        if (last_c) begin
                            state_nxt = SEQ_SETTLE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                SEQ_SETTLE: begin
                    if (err || (run_lat == '0)) begin
                        state_nxt = SEQ_DONE;
                    end else begin
                        state_nxt = SEQ_RUN;
                        cnt_nxt   = run_lat;
                    end
                end
                SEQ_RUN: begin
                    if (cnt == SEQ_CNT_W'(1)) begin
                        state_nxt = SEQ_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - SEQ_CNT_W'(1);
                    end
                end
                SEQ_DONE: begin
                    state_nxt = SEQ_IDLE;
                end
                default: begin
                    state_nxt = SEQ_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEQ_IDLE;
            idx       <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            ctrl_load <= '0;
            pe_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            cfg_ready <= (state_nxt == SEQ_LOAD);
            ctrl_load <= xfer_c ? (NUM_PE'(1) << idx) : '0;
            pe_en     <= (state_nxt == SEQ_RUN);
            busy      <= (state_nxt != SEQ_IDLE);
            done      <= (state_nxt == SEQ_DONE);
        end
    end

endmodule
